// File: rtl/bonus_ship_ctrl_pkg.sv
// Shared types and constants for the bonus ship controller: state encoding,
// mystery-ship score table and the score width.
package bonus_pkg;

  localparam int SCORE_W = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    HIT    = 2'd3
  } bonus_state_t;

  localparam logic [SCORE_W-1:0] BONUS_SCORE_0 = 9'd50;
  localparam logic [SCORE_W-1:0] BONUS_SCORE_1 = 9'd100;
  localparam logic [SCORE_W-1:0] BONUS_SCORE_2 = 9'd150;
  localparam logic [SCORE_W-1:0] BONUS_SCORE_3 = 9'd300;

  // Points for a kill, indexed by the shot count modulo 4.
  function automatic logic [SCORE_W-1:0] score_lookup(input logic [1:0] shots);
    logic [SCORE_W-1:0] pts;
    case (shots)
      2'd0:    pts = BONUS_SCORE_0;
      2'd1:    pts = BONUS_SCORE_1;
      2'd2:    pts = BONUS_SCORE_2;
      2'd3:    pts = BONUS_SCORE_3;
      default: pts = BONUS_SCORE_0;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/bonus_ship_ctrl_frame_timer.sv
// Saturating frame counter: synchronous clear, startOfFrame enable, and a
// terminal-count flag that is only valid on an enabled (frame-start) cycle.
module frame_timer #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_i,
  output logic             tc_hit_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear beats increment so a state entry on a frame start restarts at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_hit_o = en_i & (cnt_q == tc_i);

endmodule

// File: rtl/bonus_ship_ctrl.sv
// Bonus ship life-cycle sequencer: spawn scheduling, ship/fire overlap
// detection, and mystery-ship score delivery over a valid/ready handshake.
module bonus_ship_ctrl
  import bonus_pkg::*;
#(
  parameter int SPAWN_FRAMES  = 600,
  parameter int ACTIVE_FRAMES = 240,
  parameter int HIT_FRAMES    = 15,
  parameter int CNT_W         = 10
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               standBy,
  input  logic               gameEnded,
  input  logic               bonus_ship_DR,
  input  logic               playerFire_DR,
  input  logic               playerShot,
  input  logic               scoreReady,
  output logic               rise,
  output logic               bonusFireCollision,
  output logic               scoreValid,
  output logic [SCORE_W-1:0] scoreValue,
  output logic               bonusActive
);

  bonus_state_t state_q, state_d;

  logic               play_en_s;
  logic               overlap_s;
  logic               hit_s;
  logic               tc_hit_s;
  logic               clr_s;
  logic [CNT_W-1:0]   tc_s;

  logic               hit_latch_q, hit_latch_d;
  logic [1:0]         shot_cnt_q, shot_cnt_d;
  logic               rise_q, rise_d;
  logic               coll_q, coll_d;
  logic               active_q, active_d;
  logic               valid_q, valid_d;
  logic [SCORE_W-1:0] value_q, value_d;

  assign play_en_s = ~standBy & ~gameEnded;
  assign overlap_s = (state_q == ACTIVE) & bonus_ship_DR & playerFire_DR;
  assign hit_s     = overlap_s & ~hit_latch_q;
  assign clr_s     = (state_d != state_q);

  always_comb begin
    tc_s = '0;
    case (state_q)
      IDLE:    tc_s = '0;
      WAIT:    tc_s = CNT_W'(SPAWN_FRAMES - 1);
      ACTIVE:  tc_s = CNT_W'(ACTIVE_FRAMES - 1);
      HIT:     tc_s = CNT_W'(HIT_FRAMES - 1);
      default: tc_s = '0;
    endcase
  end

  frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk      (clk),
    .resetN   (resetN),
    .clr_i    (clr_s),
    .en_i     (startOfFrame),
    .tc_i     (tc_s),
    .tc_hit_o (tc_hit_s)
  );

  // Losing play overrides everything; inside ACTIVE a hit beats the timeout.
  always_comb begin
    state_d = state_q;
    if (!play_en_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = WAIT;
        WAIT:    state_d = tc_hit_s ? ACTIVE : WAIT;
        ACTIVE: begin
          if (hit_s) begin
            state_d = HIT;
          end else if (tc_hit_s) begin
            state_d = WAIT;
          end else begin
            state_d = ACTIVE;
          end
        end
        HIT:     state_d = tc_hit_s ? WAIT : HIT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    hit_latch_d = hit_latch_q;
    shot_cnt_d  = shot_cnt_q;
    if (state_q == IDLE) begin
      hit_latch_d = 1'b0;
      shot_cnt_d  = 2'd0;
    end else begin
      if (overlap_s) begin
        hit_latch_d = 1'b1;
      end else if (startOfFrame) begin
        hit_latch_d = 1'b0;
      end else begin
        hit_latch_d = hit_latch_q;
      end
      if (playerShot) begin
        shot_cnt_d = shot_cnt_q + 2'd1;
      end else begin
        shot_cnt_d = shot_cnt_q;
      end
    end
  end

  // A pending score is never overwritten in place; a new kill only loads once the old one leaves.
  always_comb begin
    valid_d = valid_q;
    value_d = value_q;
    if (state_d == IDLE) begin
      valid_d = 1'b0;
    end else if (hit_s && (!valid_q || scoreReady)) begin
      valid_d = 1'b1;
      value_d = score_lookup(shot_cnt_q);
    end else if (valid_q && scoreReady) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_comb begin
    rise_d   = (state_q == WAIT)   && (state_d == ACTIVE);
    coll_d   = (state_q == ACTIVE) && (state_d == HIT);
    active_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      hit_latch_q <= 1'b0;
      shot_cnt_q  <= 2'd0;
      rise_q      <= 1'b0;
      coll_q      <= 1'b0;
      active_q    <= 1'b0;
      valid_q     <= 1'b0;
      value_q     <= '0;
    end else begin
      state_q     <= state_d;
      hit_latch_q <= hit_latch_d;
      shot_cnt_q  <= shot_cnt_d;
      rise_q      <= rise_d;
      coll_q      <= coll_d;
      active_q    <= active_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
    end
  end

  assign rise               = rise_q;
  assign bonusFireCollision = coll_q;
  assign bonusActive        = active_q;
  assign scoreValid         = valid_q;
  assign scoreValue         = value_q;

endmodule

// File: tb/tb_bonus_ship_ctrl.sv
// Bench for bonus_ship_ctrl: directed scenarios plus a randomized run against
// a frame-countdown reference model.
module tb_bonus_ship_ctrl;

  localparam int SPAWN = 4;
  localparam int ACTF  = 6;
  localparam int HITF  = 3;
  localparam int S_IDLE = 0, S_WAIT = 1, S_ACT = 2, S_HIT = 3;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic sof = 1'b0, standBy = 1'b1, gameEnded = 1'b0;
  logic bdr = 1'b0, fdr = 1'b0, shot = 1'b0, ready = 1'b0;
  logic rise, coll, valid, active;
  logic [8:0] value;

  int checks = 0;
  int errors = 0;
  int score_tab [4] = '{50, 100, 150, 300};

  // reference model: phase, frames left in phase, shots since idle, pending score
  int m_state, m_left, m_shots, m_score;
  bit m_pending, e_rise, e_coll, e_active;

  bonus_ship_ctrl #(
    .SPAWN_FRAMES (SPAWN),
    .ACTIVE_FRAMES(ACTF),
    .HIT_FRAMES   (HITF),
    .CNT_W        (10)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .startOfFrame      (sof),
    .standBy           (standBy),
    .gameEnded         (gameEnded),
    .bonus_ship_DR     (bdr),
    .playerFire_DR     (fdr),
    .playerShot        (shot),
    .scoreReady        (ready),
    .rise              (rise),
    .bonusFireCollision(coll),
    .scoreValid        (valid),
    .scoreValue        (value),
    .bonusActive       (active)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = S_IDLE; m_left = 0; m_shots = 0; m_score = 0;
    m_pending = 1'b0; e_rise = 1'b0; e_coll = 1'b0; e_active = 1'b0;
  endtask

  task automatic model_step();
    bit play, hit;
    int nxt;
    play = !standBy && !gameEnded;
    hit  = (m_state == S_ACT) && bdr && fdr;
    nxt  = m_state;
    if (!play) nxt = S_IDLE;
    else if (m_state == S_IDLE) nxt = S_WAIT;
    else if (hit) nxt = S_HIT;
    else if (sof && m_left == 1) nxt = (m_state == S_WAIT) ? S_ACT : S_WAIT;
    else if (sof) m_left = m_left - 1;
    if (!play) m_pending = 1'b0;
    else if (hit && (!m_pending || ready)) begin
      m_pending = 1'b1;
      m_score = score_tab[m_shots];
    end else if (m_pending && ready) m_pending = 1'b0;
    if (m_state == S_IDLE) m_shots = 0;
    else if (shot) m_shots = (m_shots + 1) % 4;
    e_rise   = (m_state == S_WAIT) && (nxt == S_ACT);
    e_coll   = (m_state == S_ACT) && (nxt == S_HIT);
    e_active = (nxt == S_ACT);
    if (nxt != m_state)
      m_left = (nxt == S_WAIT) ? SPAWN : (nxt == S_ACT) ? ACTF : (nxt == S_HIT) ? HITF : 0;
    m_state = nxt;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic frame();
    sof = 1'b1; tick(); sof = 1'b0;
    repeat (3) tick();
  endtask

  task automatic go_active_fresh();
    int g = 0;
    while (m_state == S_ACT && g < 40) begin frame(); g++; end
    while (m_state != S_ACT && g < 80) begin frame(); g++; end
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL go_active got %0b want 1", active); end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rise !== 1'b0)   begin errors++; $display("FAIL reset_rise got %0b want 0", rise); end
    checks++; if (coll !== 1'b0)   begin errors++; $display("FAIL reset_coll got %0b want 0", coll); end
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
    checks++; if (value !== 9'd0)  begin errors++; $display("FAIL reset_value got %0d want 0", value); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b want 0", active); end
    resetN = 1'b1;
    model_reset();
    tick(); tick();
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL standby_active got %0b want 0", active); end
  endtask

  task automatic test_spawn();
    int nrise = 0;
    standBy = 1'b0;
    tick();
    for (int f = 1; f <= SPAWN; f++) begin
      sof = 1'b1; tick(); sof = 1'b0;
      checks++; if (rise !== 1'(f == SPAWN))   begin errors++; $display("FAIL spawn_rise f=%0d got %0b want %0b", f, rise, f == SPAWN); end
      checks++; if (active !== 1'(f == SPAWN)) begin errors++; $display("FAIL spawn_active f=%0d got %0b want %0b", f, active, f == SPAWN); end
      if (rise === 1'b1) nrise++;
      repeat (3) begin tick(); if (rise === 1'b1) nrise++; end
    end
    checks++; if (nrise != 1) begin errors++; $display("FAIL spawn_rise_count got %0d want 1", nrise); end
  endtask

  task automatic test_hit_score();
    shot = 1'b1; tick(); shot = 1'b0; tick();
    shot = 1'b1; tick(); shot = 1'b0; tick();
    bdr = 1'b1; fdr = 1'b1; tick(); bdr = 1'b0; fdr = 1'b0;
    checks++; if (coll !== 1'b1)    begin errors++; $display("FAIL hit_coll got %0b want 1", coll); end
    checks++; if (valid !== 1'b1)   begin errors++; $display("FAIL hit_valid got %0b want 1", valid); end
    checks++; if (value !== 9'd150) begin errors++; $display("FAIL hit_value got %0d want 150", value); end
    checks++; if (active !== 1'b0)  begin errors++; $display("FAIL hit_active got %0b want 0", active); end
    tick();
    checks++; if (coll !== 1'b0)    begin errors++; $display("FAIL hit_coll_width got %0b want 0", coll); end
  endtask

  task automatic test_ready_stall();
    for (int f = 0; f < 20; f++) begin
      for (int c = 0; c < 4; c++) begin
        sof = (c == 0); tick();
        checks++; if (valid !== 1'b1 || value !== 9'd150) begin
          errors++; $display("FAIL stall_hold f=%0d got valid=%0b value=%0d want 1/150", f, valid, value);
        end
      end
    end
    sof = 1'b0;
    ready = 1'b1; tick(); ready = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL stall_accept_drop got %0b want 0", valid); end
  endtask

  task automatic test_timeout();
    int ncoll = 0, nvalid = 0;
    go_active_fresh();
    for (int f = 1; f <= ACTF; f++) begin
      sof = 1'b1; tick(); sof = 1'b0;
      checks++; if (active !== 1'(f < ACTF)) begin errors++; $display("FAIL timeout_active f=%0d got %0b want %0b", f, active, f < ACTF); end
      if (coll === 1'b1) ncoll++;
      if (valid === 1'b1) nvalid++;
      repeat (3) begin tick(); if (coll === 1'b1) ncoll++; if (valid === 1'b1) nvalid++; end
    end
    checks++; if (ncoll != 0)  begin errors++; $display("FAIL timeout_coll got %0d want 0", ncoll); end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL timeout_valid got %0d want 0", nvalid); end
  endtask

  task automatic test_multi_overlap();
    int ncoll = 0, nrise_v = 0, exp_val;
    logic prev_v;
    go_active_fresh();
    repeat ($urandom_range(0, 3)) begin shot = 1'b1; tick(); shot = 1'b0; tick(); end
    exp_val = score_tab[m_shots];
    prev_v = valid;
    for (int i = 0; i < 10; i++) begin
      bdr = 1'b1; fdr = 1'b1; tick(); bdr = 1'b0; fdr = 1'b0;
      if (coll === 1'b1) ncoll++;
      if (valid === 1'b1 && prev_v !== 1'b1) nrise_v++;
      prev_v = valid;
      tick();
      if (coll === 1'b1) ncoll++;
    end
    bdr = 1'b1; fdr = 1'b1; tick(); bdr = 1'b0; fdr = 1'b0;
    repeat (3) begin tick(); if (coll === 1'b1) ncoll++; end
    checks++; if (ncoll != 1)   begin errors++; $display("FAIL multi_coll got %0d want 1", ncoll); end
    checks++; if (nrise_v != 1) begin errors++; $display("FAIL multi_score_count got %0d want 1", nrise_v); end
    checks++; if (value !== 9'(exp_val)) begin errors++; $display("FAIL multi_value got %0d want %0d", value, exp_val); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_hit_wins();
    go_active_fresh();
    repeat (ACTF - 1) frame();
    sof = 1'b1; bdr = 1'b1; fdr = 1'b1; tick();
    sof = 1'b0; bdr = 1'b0; fdr = 1'b0;
    checks++; if (coll !== 1'b1)  begin errors++; $display("FAIL hitwins_coll got %0b want 1", coll); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hitwins_valid got %0b want 1", valid); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_game_end();
    go_active_fresh();
    bdr = 1'b1; fdr = 1'b1; tick(); bdr = 1'b0; fdr = 1'b0;
    tick();
    gameEnded = 1'b1; tick();
    checks++; if (valid !== 1'b0)  begin errors++; $display("FAIL end_valid got %0b want 0", valid); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL end_active got %0b want 0", active); end
    gameEnded = 1'b0; tick();
    for (int f = 1; f <= SPAWN; f++) begin
      sof = 1'b1; tick(); sof = 1'b0;
      checks++; if (rise !== 1'(f == SPAWN)) begin errors++; $display("FAIL end_respawn f=%0d got %0b want %0b", f, rise, f == SPAWN); end
      repeat (3) tick();
    end
    bdr = 1'b1; fdr = 1'b1; tick(); bdr = 1'b0; fdr = 1'b0;
    checks++; if (value !== 9'd50) begin errors++; $display("FAIL end_value got %0d want 50", value); end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_async_reset();
    go_active_fresh();
    bdr = 1'b1; fdr = 1'b1; tick(); bdr = 1'b0; fdr = 1'b0;
    #2 resetN = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || value !== 9'd0 || coll !== 1'b0 || active !== 1'b0 || rise !== 1'b0) begin
      errors++; $display("FAIL async_reset got valid=%0b value=%0d coll=%0b active=%0b rise=%0b want all 0", valid, value, coll, active, rise);
    end
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      sof   = ($urandom_range(0, 3) == 0);
      bdr   = ($urandom_range(0, 7) == 0);
      fdr   = ($urandom_range(0, 3) == 0);
      shot  = ($urandom_range(0, 7) == 0);
      ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) standBy = ~standBy;
      if ($urandom_range(0, 499) == 0) gameEnded = ~gameEnded;
      tick();
      checks++; if ({rise, coll, valid, active} !== {e_rise, e_coll, m_pending, e_active}) begin
        errors++; $display("FAIL rand_flags cyc=%0d got %b want %b", i, {rise, coll, valid, active}, {e_rise, e_coll, m_pending, e_active});
      end
      checks++; if (value !== 9'(m_score)) begin
        errors++; $display("FAIL rand_value cyc=%0d got %0d want %0d", i, value, m_score);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_spawn();
    test_hit_score();
    test_ready_stall();
    test_timeout();
    test_multi_overlap();
    test_hit_wins();
    test_game_end();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
